// File: rtl/cpu_sequencer_if.sv
// Bus bundle between the multi-cycle sequencer and the instruction memory,
// data memory, register file and combinational decoder.
interface cpu_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        ctl_halt;
  logic        ctl_rf_we;
  logic        ctl_mem_we;
  logic        ctl_branch_taken;
  logic [11:0] ctl_imm12;
  logic        dmem_req;
  logic        dmem_ready;
  logic        rf_we;

  modport master (
    output imem_req, imem_addr, instr, dmem_req, rf_we,
    input  imem_ready, imem_rdata, ctl_halt, ctl_rf_we, ctl_mem_we,
           ctl_branch_taken, ctl_imm12, dmem_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr, dmem_req, rf_we,
    output imem_ready, imem_rdata, ctl_halt, ctl_rf_we, ctl_mem_we,
           ctl_branch_taken, ctl_imm12, dmem_ready
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: owns the PC, steps FETCH/EXEC/MEM/WB and
// gates the write strobes so each fires once per instruction.
module cpu_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic             i_step,
  cpu_sequencer_if.master  bus,
  output logic [31:0]      o_pc,
  output logic             o_halted,
  output logic             o_fault,
  output logic [CNT_W-1:0] o_retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
  } state_t;

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            r_state;
  logic [31:0]       r_pc;
  logic [31:0]       r_instr;
  logic [CNT_W-1:0]  r_retired;
  logic [WAIT_W-1:0] r_wait;
  logic              r_step_d;
  logic              r_imem_req;
  logic              r_dmem_req;
  logic              r_rf_we;
  logic              r_halted;
  logic              r_fault;

  logic              w_step_rise;
  logic              w_timeout;
  logic [31:0]       w_branch_off;

  assign w_step_rise  = i_step & ~r_step_d;
  // The wait counter holds the number of ready-less cycles already spent;
  // the cycle that would bring it to TIMEOUT is the faulting one.
  assign w_timeout    = (TIMEOUT != 0) && (r_wait == WAIT_W'(TIMEOUT - 1));
  assign w_branch_off = {{20{bus.ctl_imm12[11]}}, bus.ctl_imm12};

  // NOTE: sequential state uses non-blocking assignments only, and the async
  // reset clears every request so a reset mid-transaction drops it at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_retired  <= '0;
      r_wait     <= '0;
      r_step_d   <= 1'b0;
      r_imem_req <= 1'b0;
      r_dmem_req <= 1'b0;
      r_rf_we    <= 1'b0;
      r_halted   <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_step_d <= i_step;
      r_rf_we  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_run || w_step_rise) begin
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
            r_wait     <= '0;
          end
        end
        S_FETCH: begin
          if (bus.imem_ready) begin
            r_instr    <= bus.imem_rdata;
            r_imem_req <= 1'b0;
            r_state    <= S_EXEC;
          end else if (w_timeout) begin
            r_imem_req <= 1'b0;
            r_fault    <= 1'b1;
            r_state    <= S_FAULT;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_EXEC: begin
          if (bus.ctl_halt) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else if (bus.ctl_mem_we) begin
            r_dmem_req <= 1'b1;
            r_wait     <= '0;
            r_state    <= S_MEM;
          end else begin
            r_rf_we <= bus.ctl_rf_we;
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (bus.dmem_ready) begin
            r_dmem_req <= 1'b0;
            r_rf_we    <= bus.ctl_rf_we;
            r_state    <= S_WB;
          end else if (w_timeout) begin
            r_dmem_req <= 1'b0;
            r_fault    <= 1'b1;
            r_state    <= S_FAULT;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_WB: begin
          r_pc      <= bus.ctl_branch_taken ? (r_pc + w_branch_off) : (r_pc + 32'd4);
          r_retired <= r_retired + CNT_W'(1);
          if (i_run) begin
            r_imem_req <= 1'b1;
            r_wait     <= '0;
            r_state    <= S_FETCH;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_HALT:  r_state <= S_HALT;
        S_FAULT: r_state <= S_FAULT;
        default: r_state <= S_FAULT;
      endcase
    end
  end

  assign bus.imem_req  = r_imem_req;
  assign bus.imem_addr = r_pc;
  assign bus.instr     = r_instr;
  assign bus.dmem_req  = r_dmem_req;
  assign bus.rf_we     = r_rf_we;
  assign o_pc          = r_pc;
  assign o_halted      = r_halted;
  assign o_fault       = r_fault;
  assign o_retired     = r_retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: a toy decoder and memory models surround
// the DUT; expected retirements are queued up front and checked by a monitor.
module tb_cpu_sequencer;

  localparam logic [31:0] I_ADDI   = 32'h0050_0093;
  localparam logic [31:0] I_NOP    = 32'h0000_0013;
  localparam logic [31:0] I_BR_T   = 32'hFF80_00E3;  // bit7 = taken, imm12 = -8
  localparam logic [31:0] I_BR_NT  = 32'hFF80_0063;
  localparam logic [31:0] I_STORE  = 32'h0011_2023;
  localparam logic [31:0] I_EBREAK = 32'h0010_0073;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ret;
    int          rf;
    int          dm;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [31:0] pc;
  logic        halted;
  logic        fault;
  logic [31:0] retired;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] imem [64];
  int          imem_lat = 0;
  int          dmem_lat = 5;
  bit          imem_dead = 1'b0;
  int          icnt = 0;
  int          dcnt = 0;

  exp_t sb[$];

  always #5 clk = ~clk;

  cpu_sequencer_if bus();

  cpu_sequencer #(.RESET_PC(32'h0), .CNT_W(32), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_run     (run),
    .i_step    (step),
    .bus       (bus),
    .o_pc      (pc),
    .o_halted  (halted),
    .o_fault   (fault),
    .o_retired (retired)
  );

  // Toy decoder: opcode selects the class, bit7 is the branch outcome.
  always_comb begin
    bus.ctl_halt         = 1'b0;
    bus.ctl_rf_we        = 1'b0;
    bus.ctl_mem_we       = 1'b0;
    bus.ctl_branch_taken = 1'b0;
    bus.ctl_imm12        = bus.instr[31:20];
    case (bus.instr[6:0])
      7'h13:   bus.ctl_rf_we        = 1'b1;
      7'h23:   bus.ctl_mem_we       = 1'b1;
      7'h63:   bus.ctl_branch_taken = bus.instr[7];
      default: bus.ctl_halt         = 1'b1;
    endcase
  end

  always_comb begin
    bus.imem_ready = bus.imem_req && !imem_dead && (icnt >= imem_lat);
    bus.imem_rdata = imem[bus.imem_addr[7:2]];
    bus.dmem_ready = bus.dmem_req && (dcnt >= dmem_lat);
  end

  always_ff @(posedge clk) begin
    icnt <= (!bus.imem_req || bus.imem_ready) ? 0 : icnt + 1;
    dcnt <= (!bus.dmem_req || bus.dmem_ready) ? 0 : dcnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] p, input logic [31:0] r,
                          input int rf, input int dm, input int lat);
    exp_t e;
    e.pc = p; e.ret = r; e.rf = rf; e.dm = dm; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    run   = 1'b0;
    step  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ret(input logic [31:0] target, input int budget);
    int n = 0;
    while (retired !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_retired", retired, target);
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("halt_reached", {31'b0, halted}, 32'd1);
  endtask

  // Monitor: each retirement pops one expectation and compares PC, count,
  // strobe counts and instruction latency measured from the first fetch cycle.
  logic [31:0] last_ret;
  int          lat_c, rf_c, dm_c;
  bit          active, overlap;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_ret = '0;
      lat_c = 0; rf_c = 0; dm_c = 0;
      active = 1'b0; overlap = 1'b0;
    end else begin
      if (retired !== last_ret) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_retire: got retired=%0d with empty scoreboard", retired);
        end else begin
          mon_e = sb.pop_front();
          check("ret_pc",      pc,                 mon_e.pc);
          check("ret_count",   retired,            mon_e.ret);
          check("ret_rf_we",   32'(rf_c),          32'(mon_e.rf));
          check("ret_dmem",    32'(dm_c),          32'(mon_e.dm));
          check("ret_latency", 32'(lat_c),         32'(mon_e.lat));
          check("ret_overlap", {31'b0, overlap},   32'd0);
        end
        last_ret = retired;
        lat_c = 0; rf_c = 0; dm_c = 0;
        active = 1'b0; overlap = 1'b0;
      end
      if (bus.imem_req && !active) active = 1'b1;
      if (active) begin
        lat_c++;
        if (bus.rf_we)   rf_c++;
        if (bus.dmem_req) dm_c++;
        if (bus.rf_we && bus.dmem_req) overlap = 1'b1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cycles;
    for (int i = 0; i < 64; i++) imem[i] = I_NOP;

    // Free run: ADDI, NOPs, taken/not-taken branch at 0x10, delayed store, ebreak.
    imem[0] = I_ADDI; imem[4] = I_BR_T; imem[5] = I_STORE; imem[6] = I_EBREAK;
    push_exp(32'h04, 1, 1, 0, 3);
    push_exp(32'h08, 2, 1, 0, 3);
    push_exp(32'h0C, 3, 1, 0, 3);
    push_exp(32'h10, 4, 1, 0, 3);
    push_exp(32'h08, 5, 0, 0, 3);
    push_exp(32'h0C, 6, 1, 0, 3);
    push_exp(32'h10, 7, 1, 0, 3);
    push_exp(32'h14, 8, 0, 0, 3);
    push_exp(32'h18, 9, 0, 6, 9);
    do_reset();
    @(negedge clk);
    check("rst_pc",       pc,                      32'h0);
    check("rst_retired",  retired,                 32'h0);
    check("rst_halted",   {31'b0, halted},         32'd0);
    check("rst_fault",    {31'b0, fault},          32'd0);
    check("rst_imem_req", {31'b0, bus.imem_req},   32'd0);
    check("rst_instr",    bus.instr,               32'h0);
    run = 1'b1;
    wait_ret(5, 100);
    imem[4] = I_BR_NT;
    wait_ret(9, 200);
    wait_halt(20);
    check("a_halt_pc",      pc,                     32'h18);
    check("a_halt_retired", retired,                32'd9);
    check("a_halt_req",     {31'b0, bus.imem_req},  32'd0);
    repeat (10) @(negedge clk);
    check("a_frozen_pc",    pc,                     32'h18);
    check("a_frozen_ret",   retired,                32'd9);

    // Single-step: three rising edges, one held for ten cycles.
    for (int i = 0; i < 64; i++) imem[i] = I_NOP;
    push_exp(32'h04, 1, 1, 0, 3);
    push_exp(32'h08, 2, 1, 0, 3);
    push_exp(32'h0C, 3, 1, 0, 3);
    do_reset();
    repeat (3) @(negedge clk);
    check("b_idle_ret0", retired, 32'd0);
    step = 1'b1; @(negedge clk); step = 1'b0;
    repeat (8) @(negedge clk);
    check("b_ret1",      retired,               32'd1);
    check("b_idle_req",  {31'b0, bus.imem_req}, 32'd0);
    step = 1'b1;
    repeat (10) @(negedge clk);
    check("b_held_ret2", retired,               32'd2);
    step = 1'b0;
    repeat (3) @(negedge clk);
    step = 1'b1; repeat (2) @(negedge clk); step = 1'b0;
    repeat (8) @(negedge clk);
    check("b_ret3",      retired, 32'd3);
    check("b_pc",        pc,      32'h0C);

    // Halt after two instructions; run toggling afterwards must be ignored.
    imem[2] = I_EBREAK;
    push_exp(32'h04, 1, 1, 0, 3);
    push_exp(32'h08, 2, 1, 0, 3);
    do_reset();
    run = 1'b1;
    wait_ret(2, 50);
    wait_halt(20);
    check("c_pc",      pc,      32'h08);
    check("c_retired", retired, 32'd2);
    run = 1'b0; repeat (3) @(negedge clk);
    run = 1'b1; repeat (5) @(negedge clk);
    check("c_frozen_pc",  pc,                32'h08);
    check("c_frozen_ret", retired,           32'd2);
    check("c_fault",      {31'b0, fault},    32'd0);

    // Fetch timeout, then an asynchronous reset in the middle of a fetch.
    imem_dead = 1'b1;
    do_reset();
    run = 1'b1;
    req_cycles = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (fault) break;
      if (bus.imem_req) req_cycles++;
    end
    check("d_fault",      {31'b0, fault},        32'd1);
    check("d_req_cycles", 32'(req_cycles),       32'd16);
    check("d_req_drop",   {31'b0, bus.imem_req}, 32'd0);
    check("d_retired",    retired,               32'd0);
    do_reset();
    run = 1'b1;
    repeat (4) @(negedge clk);
    check("d_mid_fetch_req", {31'b0, bus.imem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("d_async_req",   {31'b0, bus.imem_req}, 32'd0);
    check("d_async_pc",    pc,                    32'h0);
    check("d_async_fault", {31'b0, fault},        32'd0);
    run = 1'b0;
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
